// File: rtl/ex_stage_alu_if.sv
// ID/EX, MEM/WB forwarding and EX/MEM output bundle of the execute stage.
// The hazard-unit stall/flush controls travel with the bundle; clk/nrst stay plain.
`timescale 1ns/1ps

interface ex_stage_alu_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [2:0]        id_aluop;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alusrc;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_branch;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_take_br;
  logic              ex_ovf;

  modport master (
    output stall, flush, id_valid, id_aluop, id_rs_data, id_rt_data, id_imm,
           id_alusrc, id_rs, id_rt, id_dst, id_regwrite, id_memread,
           id_memwrite, id_branch, wb_regwrite, wb_dst, wb_data,
    input  ex_valid, ex_result, ex_store_data, ex_dst, ex_regwrite,
           ex_memread, ex_memwrite, ex_take_br, ex_ovf
  );

  modport slave (
    input  stall, flush, id_valid, id_aluop, id_rs_data, id_rt_data, id_imm,
           id_alusrc, id_rs, id_rt, id_dst, id_regwrite, id_memread,
           id_memwrite, id_branch, wb_regwrite, wb_dst, wb_data,
    output ex_valid, ex_result, ex_store_data, ex_dst, ex_regwrite,
           ex_memread, ex_memwrite, ex_take_br, ex_ovf
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Optional feature: define OVF_TRAP_EN to flag add/sub signed overflow and suppress regwrite.
`timescale 1ns/1ps

module ex_stage_alu #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           nrst,
  ex_stage_alu_if.slave  bus
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SLT = 3'd6,
    ALU_LUI = 3'd7
  } aluop_e;

  localparam int MSB = DATA_W - 1;

  logic              valid_q, regwrite_q, memread_q, memwrite_q, take_br_q, ovf_q;
  logic [DATA_W-1:0] result_q, store_q;
  logic [REG_AW-1:0] dst_q;

  logic [DATA_W-1:0] op_a, fwd_rt, op_b, alu_res;
  logic              ovf_d, regwrite_d, bubble;
  aluop_e            op;

  // Pick the youngest producer of a source register; register 0 is hard-wired zero.
  function automatic logic [DATA_W-1:0] forward(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] id_data
  );
    if (addr != '0 && valid_q && regwrite_q && dst_q == addr)
      forward = result_q;
    else if (addr != '0 && bus.wb_regwrite && bus.wb_dst == addr)
      forward = bus.wb_data;
    else
      forward = id_data;
  endfunction

  assign op     = aluop_e'(bus.id_aluop);
  assign op_a   = forward(bus.id_rs, bus.id_rs_data);
  assign fwd_rt = forward(bus.id_rt, bus.id_rt_data);
  assign op_b   = bus.id_alusrc ? bus.id_imm : fwd_rt;
  assign bubble = bus.flush || !bus.id_valid;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_LUI: alu_res = {op_b[DATA_W-17:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ovf_d = 1'b0;
`ifdef OVF_TRAP_EN
    if (op == ALU_ADD)
      ovf_d = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
    else if (op == ALU_SUB)
      ovf_d = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
`else
    ovf_d = 1'b0;
`endif
    regwrite_d = bus.id_regwrite && !ovf_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      dst_q      <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      take_br_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (bus.flush || (!bus.stall && bubble)) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      dst_q      <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      take_br_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (!bus.stall) begin
      valid_q    <= 1'b1;
      result_q   <= alu_res;
      store_q    <= fwd_rt;
      dst_q      <= bus.id_dst;
      regwrite_q <= regwrite_d;
      memread_q  <= bus.id_memread;
      memwrite_q <= bus.id_memwrite;
      take_br_q  <= bus.id_branch && (alu_res == '0);
      ovf_q      <= ovf_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_result     = result_q;
  assign bus.ex_store_data = store_q;
  assign bus.ex_dst        = dst_q;
  assign bus.ex_regwrite   = regwrite_q;
  assign bus.ex_memread    = memread_q;
  assign bus.ex_memwrite   = memwrite_q;
  assign bus.ex_take_br    = take_br_q;
  assign bus.ex_ovf        = ovf_q;

endmodule

// File: tb/tb_ex_stage_alu.sv
// Self-checking bench for ex_stage_alu: directed cases plus randomized traffic
// compared against an arithmetic reference model of the EX/MEM register.
`timescale 1ns/1ps

module tb_ex_stage_alu;

`ifdef OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    bit        stall, flush, valid;
    bit [2:0]  aluop;
    bit [31:0] rs_data, rt_data, imm;
    bit        alusrc;
    bit [4:0]  rs, rt, dst;
    bit        regwrite, memread, memwrite, branch;
    bit        wb_regwrite;
    bit [4:0]  wb_dst;
    bit [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  dst;
    logic        regwrite, memread, memwrite, take_br, ovf;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t model = '0;
  in_t  cur;

  ex_stage_alu_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_stage_alu #(.DATA_W(32), .REG_AW(5)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural view of a register source: r0 never forwards, youngest writer wins.
  function automatic bit [31:0] src_val(exp_t m, in_t x, bit [4:0] addr, bit [31:0] id_data);
    if (addr == 0) return id_data;
    if (m.valid && m.regwrite && m.dst == addr) return m.result;
    if (x.wb_regwrite && x.wb_dst == addr) return x.wb_data;
    return id_data;
  endfunction

  function automatic exp_t model_next(exp_t m, in_t x);
    exp_t      n;
    bit [31:0] a, rt_v, b, r;
    longint    sa, sb, s;
    bit        ovf;
    if (x.flush || (!x.stall && !x.valid)) return '0;
    if (x.stall) return m;
    a    = src_val(m, x, x.rs, x.rs_data);
    rt_v = src_val(m, x, x.rt, x.rt_data);
    b    = x.alusrc ? x.imm : rt_v;
    case (x.aluop)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = b * 32'd65536;
    endcase
    sa  = $signed(a);
    sb  = $signed(b);
    s   = (x.aluop == 3'd0) ? sa + sb : sa - sb;
    ovf = TRAP && (x.aluop <= 3'd1) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    n.valid    = 1'b1;
    n.result   = r;
    n.store    = rt_v;
    n.dst      = x.dst;
    n.regwrite = x.regwrite && !ovf;
    n.memread  = x.memread;
    n.memwrite = x.memwrite;
    n.take_br  = x.branch && (r == 0);
    n.ovf      = ovf;
    return n;
  endfunction

  function automatic in_t base();
    in_t x;
    x = '{default: '0};
    x.valid = 1'b1;
    return x;
  endfunction

  function automatic bit [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF - $urandom_range(0, 3);
      1: return 32'h8000_0000 + $urandom_range(0, 3);
      2: return $urandom_range(0, 4);
      default: return $urandom;
    endcase
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.stall       = ($urandom_range(0, 99) < 15);
    x.flush       = ($urandom_range(0, 99) < 8);
    x.valid       = x.stall ? 1'b1 : ($urandom_range(0, 99) < 90);
    x.aluop       = 3'($urandom_range(0, 7));
    x.rs_data     = rand_word();
    x.rt_data     = rand_word();
    x.imm         = rand_word();
    x.alusrc      = $urandom_range(0, 1);
    x.rs          = 5'($urandom_range(0, 3));
    x.rt          = 5'($urandom_range(0, 3));
    x.dst         = 5'($urandom_range(0, 3));
    x.regwrite    = $urandom_range(0, 1);
    x.memread     = $urandom_range(0, 1);
    x.memwrite    = $urandom_range(0, 1);
    x.branch      = $urandom_range(0, 1);
    x.wb_regwrite = $urandom_range(0, 1);
    x.wb_dst      = 5'($urandom_range(0, 3));
    x.wb_data     = rand_word();
    return x;
  endfunction

  task automatic drive(input in_t x);
    bus.stall       = x.stall;
    bus.flush       = x.flush;
    bus.id_valid    = x.valid;
    bus.id_aluop    = x.aluop;
    bus.id_rs_data  = x.rs_data;
    bus.id_rt_data  = x.rt_data;
    bus.id_imm      = x.imm;
    bus.id_alusrc   = x.alusrc;
    bus.id_rs       = x.rs;
    bus.id_rt       = x.rt;
    bus.id_dst      = x.dst;
    bus.id_regwrite = x.regwrite;
    bus.id_memread  = x.memread;
    bus.id_memwrite = x.memwrite;
    bus.id_branch   = x.branch;
    bus.wb_regwrite = x.wb_regwrite;
    bus.wb_dst      = x.wb_dst;
    bus.wb_data     = x.wb_data;
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".valid"},    bus.ex_valid,      e.valid);
    check({tag, ".result"},   bus.ex_result,     e.result);
    check({tag, ".store"},    bus.ex_store_data, e.store);
    check({tag, ".dst"},      bus.ex_dst,        e.dst);
    check({tag, ".regwrite"}, bus.ex_regwrite,   e.regwrite);
    check({tag, ".memread"},  bus.ex_memread,    e.memread);
    check({tag, ".memwrite"}, bus.ex_memwrite,   e.memwrite);
    check({tag, ".take_br"},  bus.ex_take_br,    e.take_br);
    check({tag, ".ovf"},      bus.ex_ovf,        e.ovf);
  endtask

  // Apply cur, clock once, sample 1 ns after the edge and compare against the model.
  task automatic step(input string tag);
    exp_t nxt;
    drive(cur);
    nxt = model_next(model, cur);
    @(posedge clk);
    #1;
    model = nxt;
    compare_all(tag, model);
  endtask

  initial begin
    cur = base();
    drive(cur);
    #12;
    compare_all("reset_init", '0);
    nrst = 1'b1;

    // Basic ALU
    cur = base(); cur.aluop = 3'd0; cur.rs_data = 32'd7; cur.rt_data = 32'd5;
    step("add");
    check("add_const", bus.ex_result, 32'd12);
    cur = base(); cur.aluop = 3'd6; cur.rs_data = 32'hFFFF_FFFF; cur.rt_data = 32'd1;
    step("slt");
    check("slt_const", bus.ex_result, 32'd1);
    cur = base(); cur.aluop = 3'd7; cur.alusrc = 1'b1; cur.imm = 32'h1234;
    step("lui");
    check("lui_const", bus.ex_result, 32'h1234_0000);

    // Forwarding priority: EX/MEM beats MEM/WB, register 0 never forwards
    cur = base(); cur.rs = 5'd1; cur.rs_data = 32'hAA; cur.regwrite = 1'b1; cur.dst = 5'd3;
    step("fwd_prod");
    cur = base(); cur.aluop = 3'd3; cur.rs = 5'd3; cur.rs_data = 32'h11;
    cur.wb_regwrite = 1'b1; cur.wb_dst = 5'd3; cur.wb_data = 32'hBB;
    step("fwd_ex");
    check("fwd_ex_const", bus.ex_result, 32'hAA);
    cur = base(); cur.rs = 5'd1; cur.rs_data = 32'hAA; cur.regwrite = 1'b1; cur.dst = 5'd0;
    step("fwd_prod0");
    cur = base(); cur.aluop = 3'd3; cur.rs = 5'd0; cur.rs_data = 32'h11;
    cur.wb_regwrite = 1'b1; cur.wb_dst = 5'd0; cur.wb_data = 32'hBB;
    cur.regwrite = 1'b1; cur.dst = 5'd5;
    step("fwd_r0");
    check("fwd_r0_const", bus.ex_result, 32'h11);
    cur = base(); cur.aluop = 3'd3; cur.rs = 5'd3; cur.rs_data = 32'h11;
    cur.wb_regwrite = 1'b1; cur.wb_dst = 5'd3; cur.wb_data = 32'hBB;
    step("fwd_wb");
    check("fwd_wb_const", bus.ex_result, 32'hBB);

    // Branch resolution
    cur = base(); cur.aluop = 3'd1; cur.branch = 1'b1; cur.rs_data = 32'h55; cur.rt_data = 32'h55;
    step("br_taken");
    check("br_taken_const", bus.ex_take_br, 1'b1);
    cur.rt_data = 32'h56;
    step("br_not");
    check("br_not_const", bus.ex_take_br, 1'b0);

    // Stall holds for three edges, stall+flush bubbles
    cur = base(); cur.rs_data = 32'd100; cur.rt_data = 32'd23; cur.regwrite = 1'b1; cur.dst = 5'd7;
    step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      cur = rand_in(); cur.stall = 1'b1; cur.flush = 1'b0; cur.valid = 1'b1;
      step("stall");
      check("stall_result", bus.ex_result, 32'd123);
      check("stall_dst", bus.ex_dst, 5'd7);
    end
    cur.flush = 1'b1;
    step("stall_flush");
    check("stall_flush_valid", bus.ex_valid, 1'b0);

    // Overflow at the signed boundary
    cur = base(); cur.rs_data = 32'h7FFF_FFFF; cur.rt_data = 32'd1; cur.regwrite = 1'b1;
    step("ovf");
    check("ovf_result", bus.ex_result, 32'h8000_0000);
    check("ovf_flag", bus.ex_ovf, TRAP);
    check("ovf_regwrite", bus.ex_regwrite, !TRAP);

    // Randomized traffic, with an asynchronous reset dropped in mid-cycle
    for (int i = 0; i < 400; i++) begin
      cur = rand_in();
      step("rand");
      if (i == 200) begin
        #3;
        nrst = 1'b0;
        #1;
        model = '0;
        compare_all("reset_async", model);
        #1;
        nrst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
